// File: rtl/div_sequencer.sv
// Multi-cycle restoring divider for the EX stage: div/divu/rem/remu with
// RISC-V divide-by-zero and signed-overflow results, flushable at any point.
module div_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      divctl,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic            busy,
  output logic            div_done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [CW-1:0]   LAST    = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  // Handshake: start is taken only when the sequencer is idle and flush is
  // low; div_done is a one-cycle pulse with result valid in the same cycle,
  // and result holds its value until the next completed operation.
  typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_t;

  state_t          state, state_nx;
  logic [1:0]      ctl;
  logic [XLEN-1:0] quo, rem, dvsr, result_q;
  logic            neg_q, neg_r;
  logic [CW-1:0]   cnt;

  logic            accept, is_signed, a_neg, b_neg, div_zero, ovf, take;
  logic [XLEN-1:0] a_abs, b_abs, quo_fix, rem_fix;
  logic [XLEN:0]   rem_sh, diff;

  always_comb begin
    is_signed = ~divctl[0];
    accept    = (state == IDLE) && start && !flush;
    a_neg     = is_signed && op_a[XLEN-1];
    b_neg     = is_signed && op_b[XLEN-1];
    a_abs     = a_neg ? ('0 - op_a) : op_a;
    b_abs     = b_neg ? ('0 - op_b) : op_b;
    div_zero  = (op_b == '0);
    ovf       = is_signed && (op_a == MIN_NEG) && (op_b == '1);
    // One extra bit keeps the partial remainder exact for divisors >= 2^(XLEN-1).
    rem_sh    = {rem, quo[XLEN-1]};
    diff      = rem_sh - {1'b0, dvsr};
    take      = !diff[XLEN];
    quo_fix   = (!ctl[0] && neg_q) ? ('0 - quo) : quo;
    rem_fix   = (!ctl[0] && neg_r) ? ('0 - rem) : rem;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (accept) state_nx = (div_zero || ovf) ? DONE : ITER;
      ITER: if (cnt == LAST) state_nx = FIX;
      FIX:  state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (flush) state_nx = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ctl      <= '0;
      quo      <= '0;
      rem      <= '0;
      dvsr     <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      cnt      <= '0;
      result_q <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (accept) begin
            ctl   <= divctl;
            quo   <= a_abs;
            dvsr  <= b_abs;
            rem   <= '0;
            cnt   <= '0;
            neg_q <= a_neg ^ b_neg;
            neg_r <= a_neg;
            if (div_zero)
              result_q <= divctl[1] ? op_a : '1;
            else if (ovf)
              result_q <= divctl[1] ? '0 : op_a;
          end
        end
        ITER: begin
          rem <= take ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
          quo <= {quo[XLEN-2:0], take};
          cnt <= cnt + CW'(1);
        end
        FIX: begin
          // A flush here must leave the previous result visible.
          if (!flush) begin
            quo      <= quo_fix;
            rem      <= rem_fix;
            result_q <= ctl[1] ? rem_fix : quo_fix;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy     = (state != IDLE);
  assign div_done = (state == DONE);
  assign result   = result_q;

endmodule

// File: tb/tb_div_sequencer.sv
// Directed bench for div_sequencer: driver pushes expected result and done
// cycle into queues, a negedge monitor pops and compares on every div_done.
module tb_div_sequencer;
  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic            flush = 1'b0;
  logic [1:0]      divctl = 2'b00;
  logic [XLEN-1:0] op_a = '0;
  logic [XLEN-1:0] op_b = '0;
  logic            busy, div_done;
  logic [XLEN-1:0] result;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;

  logic [XLEN-1:0] exp_q[$];
  int              cyc_q[$];
  string           name_q[$];

  div_sequencer #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .start(start), .divctl(divctl),
    .op_a(op_a), .op_b(op_b), .flush(flush),
    .busy(busy), .div_done(div_done), .result(result)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (div_done === 1'b1) begin
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_done: result %h at cycle %0d, none expected", result, cyc);
      end else begin
        string nm;
        nm = name_q.pop_front();
        check(nm, result, exp_q.pop_front());
        check({nm, "_cycle"}, cyc, cyc_q.pop_front());
      end
    end
  end

  // driver tasks
  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (busy === 1'b0 && exp_q.size() == 0) return;
    end
    compared++;
    mismatched++;
    $display("FAIL idle_timeout: busy %b pending %0d at cycle %0d", busy, exp_q.size(), cyc);
  endtask

  task automatic start_op(input logic [1:0] ctl, input logic [31:0] a, input logic [31:0] b,
                          input bit track, input logic [31:0] exp, input int lat,
                          input string nm, output int s);
    divctl = ctl;
    op_a   = a;
    op_b   = b;
    start  = 1'b1;
    s      = cyc;
    if (track) begin
      exp_q.push_back(exp);
      cyc_q.push_back(s + lat);
      name_q.push_back(nm);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_op(input logic [1:0] ctl, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int lat, input string nm);
    int s;
    wait_idle();
    start_op(ctl, a, b, 1'b1, exp, lat, nm, s);
  endtask

  initial begin
    int s;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_done", {31'b0, div_done}, 32'd0);
    check("reset_result", result, 32'd0);

    // directed vectors: ctl 00 div, 01 divu, 10 rem, 11 remu
    run_op(2'b01, 32'd100,       32'd7,         32'd14,        34, "divu_100_7");
    run_op(2'b11, 32'd100,       32'd7,         32'd2,         34, "remu_100_7");
    run_op(2'b00, 32'hFFFFFFF9,  32'd2,         32'hFFFFFFFD,  34, "div_m7_2");
    run_op(2'b10, 32'hFFFFFFF9,  32'd2,         32'hFFFFFFFF,  34, "rem_m7_2");
    run_op(2'b00, 32'd7,         32'hFFFFFFFE,  32'hFFFFFFFD,  34, "div_7_m2");
    run_op(2'b10, 32'd7,         32'hFFFFFFFE,  32'd1,         34, "rem_7_m2");
    run_op(2'b00, 32'd5,         32'd0,         32'hFFFFFFFF,  1,  "div_5_0");
    run_op(2'b11, 32'd5,         32'd0,         32'd5,         1,  "remu_5_0");
    run_op(2'b10, 32'hFFFFFFFB,  32'd0,         32'hFFFFFFFB,  1,  "rem_m5_0");
    run_op(2'b00, 32'h80000000,  32'hFFFFFFFF,  32'h80000000,  1,  "div_ovf");
    run_op(2'b10, 32'h80000000,  32'hFFFFFFFF,  32'd0,         1,  "rem_ovf");
    run_op(2'b01, 32'h80000000,  32'hFFFFFFFF,  32'd0,         34, "divu_min_max");
    run_op(2'b11, 32'h80000000,  32'hFFFFFFFF,  32'h80000000,  34, "remu_min_max");
    run_op(2'b01, 32'hFFFFFFFF,  32'hFFFFFFFE,  32'd1,         34, "divu_big");
    run_op(2'b11, 32'hFFFFFFFF,  32'hFFFFFFFE,  32'd1,         34, "remu_big");

    // start while busy is ignored
    wait_idle();
    start_op(2'b01, 32'd100, 32'd7, 1'b1, 32'd14, 34, "divu_ignore_start", s);
    while (cyc < s + 5) @(negedge clk);
    divctl = 2'b00; op_a = 32'd50; op_b = 32'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;

    // flush mid-operation
    wait_idle();
    start_op(2'b01, 32'd1000, 32'd3, 1'b0, 32'd0, 0, "flushed", s);
    while (cyc < s + 10) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy", {31'b0, busy}, 32'd0);
    repeat (40) @(negedge clk);
    check("flush_result", result, 32'd14);

    // flush wins over start in IDLE
    start = 1'b1; flush = 1'b1; divctl = 2'b01; op_a = 32'd8; op_b = 32'd2;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    check("flush_start_busy", {31'b0, busy}, 32'd0);
    repeat (40) @(negedge clk);
    check("flush_start_result", result, 32'd14);

    // reset mid-operation
    start_op(2'b01, 32'd1000, 32'd3, 1'b0, 32'd0, 0, "reset_abort", s);
    while (cyc < s + 20) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_busy", {31'b0, busy}, 32'd0);
    check("rst_mid_result", result, 32'd0);
    repeat (40) @(negedge clk);
    run_op(2'b01, 32'd9, 32'd3, 32'd3, 34, "divu_9_3");

    wait_idle();
    check("queue_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
